move_scheduler: RTL and testbench

Sequences the shared piece-move datapath while the main game FSM is in its move phase. Merges four requesters into one request/acknowledge channel toward the move unit: gravity ticks, rotate, left and right button presses. Gravity is scheduled from a level-scaled tick counter. When a gravity drop is reported blocked, the block raises the one-cycle `touched` pulse that the main FSM consumes to start landing.

---
 rtl/tetris_pkg.sv | 38 +++
 rtl/gravity_timer.sv | 66 ++++++
 rtl/move_scheduler.sv | 150 +++++++++++++++
 tb/tb_move_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the move scheduler: op codes, scheduler states and
// the mapping from an op code to its pending-bit position.
package tetris_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_DROP  = 3'd1,
    OP_LEFT  = 3'd2,
    OP_RIGHT = 3'd3,
    OP_ROT   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LANDED = 2'd2
  } sched_state_e;

  // Pending-bit positions inside the 4-bit pending vector.
  localparam int PB_DROP  = 0;
  localparam int PB_LEFT  = 1;
  localparam int PB_RIGHT = 2;
  localparam int PB_ROT   = 3;

  // One-hot pending mask for an op; NONE maps to no bit.
  function automatic logic [3:0] op_mask(input op_e op);
    case (op)
      OP_DROP:  op_mask = 4'b0001;
      OP_LEFT:  op_mask = 4'b0010;
      OP_RIGHT: op_mask = 4'b0100;
      OP_ROT:   op_mask = 4'b1000;
      default:  op_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-scaled gravity down-counter. The period is TICK_DIV - level*STEP in
// signed 8-bit arithmetic, floored at MIN_PERIOD. Emits a one-cycle tick when
// the count reaches 1 and reloads; held at the period while disabled.
module gravity_timer
  import tetris_pkg::*;
#(
  parameter int TICK_DIV   = 16,
  parameter int STEP       = 1,
  parameter int MIN_PERIOD = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       freeze_i,
  input  logic       reload_i,
  input  logic [3:0] level_i,
  output logic       tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic signed [7:0] TICK_S = 8'(TICK_DIV);
  localparam logic signed [7:0] STEP_S = 8'(STEP);
  localparam logic signed [7:0] MIN_S  = 8'(MIN_PERIOD);

  // Saturating period computation for a given level.
  function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] lvl);
    logic signed [7:0] lvl_s;
    logic signed [7:0] p;
    lvl_s = signed'({4'b0000, lvl});
    p     = TICK_S - lvl_s * STEP_S;
    if (p < MIN_S) calc_period = CNT_W'(MIN_PERIOD);
    else           calc_period = CNT_W'(p);
  endfunction

  logic [CNT_W-1:0] period_w;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign period_w = calc_period(level_i);

  // Next count: hold at period when disabled, reload on request, freeze
  // while landed, otherwise count down and tick at 1.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!enable_i) begin
      cnt_d = period_w;
    end else if (reload_i) begin
      cnt_d = period_w;
    end else if (!freeze_i) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d  = period_w;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Counter register; comes out of reset loaded with the current period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= period_w;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/move_scheduler.sv
// Merges gravity, rotate, left and right requests into one req/ack channel
// toward the move datapath and raises `touched` when a drop is blocked.
// Optional feature: define MOVE_SCHEDULER_SOFT_DROP_EN to let a btn_down
// press request a drop and restart the gravity period.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int TICK_DIV   = 16,
  parameter int STEP       = 1,
  parameter int MIN_PERIOD = 2
) (
  input  logic            clka,
  input  logic            restart_n,
  input  logic            enable,
  input  logic [3:0]      level,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_rot,
  input  logic            btn_down,
  output logic            move_req,
  output logic [OP_W-1:0] move_op,
  input  logic            move_done,
  input  logic            move_blocked,
  output logic            touched,
  output logic            busy
);

  sched_state_e state_q;
  op_e          op_q;
  logic         req_q;
  logic         touched_q;
  logic         busy_q;

  logic [3:0]   btn_w;
  logic [3:0]   btn_q;
  logic [3:0]   edge_w;
  logic [3:0]   set_w;
  logic [3:0]   clr_w;
  logic [3:0]   pend_q;
  logic [3:0]   pend_d;
  logic         tick_w;
  logic         reload_w;
  logic         done_w;
  logic         clear_all_w;
  op_e          grant_op;

`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
  assign btn_w    = {btn_rot, btn_right, btn_left, btn_down};
  assign edge_w   = btn_w & ~btn_q;
  assign reload_w = edge_w[PB_DROP];
`else
  logic unused_btn_down;
  assign unused_btn_down = btn_down;
  assign btn_w    = {btn_rot, btn_right, btn_left, 1'b0};
  assign edge_w   = btn_w & ~btn_q;
  assign reload_w = 1'b0;
`endif

  gravity_timer #(
    .TICK_DIV   (TICK_DIV),
    .STEP       (STEP),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_grav (
    .clk_i    (clka),
    .rst_ni   (restart_n),
    .enable_i (enable),
    .freeze_i (state_q == ST_LANDED),
    .reload_i (reload_w),
    .level_i  (level),
    .tick_o   (tick_w)
  );

  assign set_w       = edge_w | {3'b000, tick_w};
  assign done_w      = (state_q == ST_BUSY) && move_done;
  assign clear_all_w = ((state_q == ST_IDLE) && !enable) || (done_w && !enable);

  // Fixed-priority grant: DROP > ROT > LEFT > RIGHT.
  always_comb begin
    grant_op = OP_NONE;
    if (pend_q[PB_DROP])       grant_op = OP_DROP;
    else if (pend_q[PB_ROT])   grant_op = OP_ROT;
    else if (pend_q[PB_LEFT])  grant_op = OP_LEFT;
    else if (pend_q[PB_RIGHT]) grant_op = OP_RIGHT;
  end

  // Pending update: a new set beats the ack clear of the same bit, so a
  // press landing on the ack cycle is queued again; disable wipes all.
  always_comb begin
    clr_w  = done_w ? op_mask(op_q) : 4'b0000;
    pend_d = (pend_q & ~clr_w) | set_w;
    if (clear_all_w) pend_d = 4'b0000;
  end

  // Button history and pending bits.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      btn_q  <= 4'b0000;
      pend_q <= 4'b0000;
    end else begin
      btn_q  <= btn_w;
      pend_q <= pend_d;
    end
  end

  // Scheduler FSM with registered handshake outputs.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      req_q     <= 1'b0;
      touched_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      touched_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && (pend_q != 4'b0000)) begin
            op_q    <= grant_op;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (move_done) begin
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            op_q   <= OP_NONE;
            if ((op_q == OP_DROP) && move_blocked) begin
              touched_q <= 1'b1;
              state_q   <= enable ? ST_LANDED : ST_IDLE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_LANDED: begin
          if (!enable) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign move_req = req_q;
  assign move_op  = op_q;
  assign touched  = touched_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler (TICK_DIV=16, STEP=1, MIN_PERIOD=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_move_scheduler;

  logic       clka;
  logic       restart_n;
  logic       enable;
  logic [3:0] level;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic       btn_down;
  logic       move_req;
  logic [2:0] move_op;
  logic       move_done;
  logic       move_blocked;
  logic       touched;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int rc     = 0;

  move_scheduler #(
    .TICK_DIV   (16),
    .STEP       (1),
    .MIN_PERIOD (2)
  ) dut (
    .clka         (clka),
    .restart_n    (restart_n),
    .enable       (enable),
    .level        (level),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_rot      (btn_rot),
    .btn_down     (btn_down),
    .move_req     (move_req),
    .move_op      (move_op),
    .move_done    (move_done),
    .move_blocked (move_blocked),
    .touched      (touched),
    .busy         (busy)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-cycle acknowledge.
  task automatic ack(input logic blk);
    move_done    = 1'b1;
    move_blocked = blk;
    step(1);
    move_done    = 1'b0;
    move_blocked = 1'b0;
  endtask

  initial begin
    restart_n    = 1'b0;
    enable       = 1'b1;
    level        = 4'd0;
    btn_left     = 1'b1;
    btn_right    = 1'b0;
    btn_rot      = 1'b0;
    btn_down     = 1'b0;
    move_done    = 1'b0;
    move_blocked = 1'b0;
    step(2);

    // Reset state
    check("rst_req", move_req, 0);
    check("rst_op", move_op, 0);
    check("rst_touched", touched, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", dut.u_grav.cnt_q, 16);
    check("rst_pend", dut.pend_q, 0);

    // Button held through reset release counts as a press
    restart_n = 1'b1;
    step(1);
    check("held_rst_pend", dut.pend_q, 4'b0010);
    step(1);
    check("held_rst_req", move_req, 1);
    check("held_rst_op", move_op, 2);
    check("held_rst_busy", busy, 1);
    ack(1'b0);
    check("held_rst_ack", move_req, 0);
    btn_left = 1'b0;
    enable   = 1'b0;
    step(2);

    // Gravity at level 0 and landing
    enable = 1'b1;
    step(16);
    check("grav_early", move_req, 0);
    step(1);
    check("grav_req", move_req, 1);
    check("grav_op", move_op, 1);
    ack(1'b1);
    check("land_req_low", move_req, 0);
    check("land_touched", touched, 1);
    check("land_busy", busy, 0);
    step(1);
    check("land_touched_once", touched, 0);
    step(40);
    check("landed_no_req", move_req, 0);
    check("landed_cnt_frozen", dut.u_grav.cnt_q, 14);
    enable = 1'b0;
    step(1);
    check("unland_cnt", dut.u_grav.cnt_q, 16);
    step(1);

    // Priority: tick, rot and left pending together
    enable = 1'b1;
    step(15);
    btn_left = 1'b1;
    btn_rot  = 1'b1;
    step(1);
    check("prio_pend", dut.pend_q, 4'b1011);
    check("prio_noreq", move_req, 0);
    step(1);
    check("prio1_op", move_op, 1);
    ack(1'b0);
    check("prio1_low", move_req, 0);
    step(1);
    check("prio2_req", move_req, 1);
    check("prio2_op", move_op, 4);
    ack(1'b0);
    check("prio2_low", move_req, 0);
    step(1);
    check("prio3_op", move_op, 2);
    ack(1'b0);
    check("prio_pend_empty", dut.pend_q, 0);
    btn_left = 1'b0;
    btn_rot  = 1'b0;
    enable   = 1'b0;
    step(2);

    // Held right button: exactly one RIGHT request over 50 cycles
    enable    = 1'b1;
    btn_right = 1'b1;
    rc        = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      move_done = move_req;
      if (move_req && move_op == 3'd3) rc++;
    end
    btn_right = 1'b0;
    enable    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      move_done = move_req;
      if (move_req && move_op == 3'd3) rc++;
    end
    move_done = 1'b0;
    step(1);
    check("held_right_count", rc, 1);

    // Re-press landing on the ack cycle is queued again
    enable    = 1'b1;
    btn_right = 1'b1;
    step(1);
    check("repress_pend", dut.pend_q, 4'b0100);
    step(1);
    check("repress_op1", move_op, 3);
    btn_right = 1'b0;
    step(1);
    btn_right = 1'b1;
    move_done = 1'b1;
    step(1);
    move_done = 1'b0;
    check("repress_low", move_req, 0);
    check("repress_pend2", dut.pend_q, 4'b0100);
    step(1);
    check("repress_req2", move_req, 1);
    check("repress_op2", move_op, 3);
    ack(1'b0);
    step(3);
    check("repress_no_third", move_req, 0);
    btn_right = 1'b0;

    // Disable during BUSY: handshake completes, then pending wiped
    enable = 1'b0;
    step(1);
    enable   = 1'b1;
    btn_left = 1'b1;
    step(2);
    check("dis_req", move_req, 1);
    enable  = 1'b0;
    btn_rot = 1'b1;
    step(3);
    check("dis_hold_req", move_req, 1);
    check("dis_hold_op", move_op, 2);
    ack(1'b0);
    check("dis_req_low", move_req, 0);
    check("dis_busy_low", busy, 0);
    check("dis_pend_clr", dut.pend_q, 0);
    check("dis_cnt_reload", dut.u_grav.cnt_q, 16);
    step(3);
    check("dis_stay_idle", move_req, 0);
    btn_left = 1'b0;
    btn_rot  = 1'b0;

    // Ack while idle is ignored
    ack(1'b1);
    check("stray_ack_touched", touched, 0);
    check("stray_ack_req", move_req, 0);

    // Level 15: period saturates to 2
    level = 4'd15;
    step(1);
    check("lvl_period", dut.u_grav.cnt_q, 2);
    enable = 1'b1;
    step(2);
    check("lvl_early", move_req, 0);
    step(1);
    check("lvl_req1", move_req, 1);
    check("lvl_op1", move_op, 1);
    ack(1'b0);
    check("lvl_gap1", move_req, 0);
    step(1);
    check("lvl_req2", move_req, 1);
    ack(1'b0);
    check("lvl_gap2", move_req, 0);
    step(1);
    check("lvl_req3", move_req, 1);
    enable = 1'b0;
    ack(1'b0);
    check("lvl_end_pend", dut.pend_q, 0);
    level = 4'd0;
    step(2);

`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
    // Soft drop at count 5 restarts the gravity period
    enable = 1'b1;
    step(11);
    check("soft_cnt5", dut.u_grav.cnt_q, 5);
    btn_down = 1'b1;
    step(1);
    check("soft_reload", dut.u_grav.cnt_q, 16);
    check("soft_pend", dut.pend_q, 4'b0001);
    step(1);
    check("soft_req", move_req, 1);
    check("soft_op", move_op, 1);
    ack(1'b0);
    btn_down = 1'b0;
    enable   = 1'b0;
    step(2);
`endif

    // Asynchronous reset mid-handshake drops the request at once
    enable  = 1'b1;
    btn_rot = 1'b1;
    step(2);
    check("arst_pre_op", move_op, 4);
    #1 restart_n = 1'b0;
    #1;
    check("arst_req", move_req, 0);
    check("arst_busy", busy, 0);
    step(1);
    restart_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
